// File: rtl/sram_param.sv
// sram_param: single-port byte-enabled SRAM with a power-up init sweep,
// configurable read latency and optional write-through into in-flight reads.
module sram_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 12,
    parameter int                DEPTH    = 4096,
    parameter int                RD_LAT   = 1,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csb,
    input  logic                wrb,
    input  logic [ADDR_W-1:0]   abus,
    input  logic [DATA_W/8-1:0] ben,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy,
    output logic                oor_err
);
    localparam int NB = DATA_W / 8;
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0] r_pv;
    logic [RD_LAT-1:0] r_po;
    logic [DATA_W-1:0] r_pd [RD_LAT];
    logic [IW-1:0]     r_pa [RD_LAT];

    logic              w_oor, w_acc, w_wr, w_rd, w_we;
    logic [IW-1:0]     w_idx, w_widx;
    logic [NB-1:0]     w_wbe;
    logic [DATA_W-1:0] w_wd;
    logic [RD_LAT-1:0] w_hit;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                                 input logic [DATA_W-1:0] new_d,
                                                 input logic [NB-1:0]     be);
        merge = old_d;
        for (int i = 0; i < NB; i++)
            if (be[i]) merge[8*i +: 8] = new_d[8*i +: 8];
    endfunction

    assign w_oor  = {1'b0, abus} >= DEPTH_L;
    assign w_acc  = !csb && r_state == S_RUN;
    assign w_wr   = w_acc && !wrb && !w_oor;
    assign w_rd   = w_acc && wrb;
    assign w_idx  = IW'(abus);

    // The sweep and user writes share the one write port; the FSM decides who owns it.
    assign w_we   = r_state == S_INIT || w_wr;
    assign w_widx = r_state == S_INIT ? IW'(r_ptr) : w_idx;
    assign w_wbe  = r_state == S_INIT ? '1 : ben;
    assign w_wd   = r_state == S_INIT ? INIT_VAL : wdata;

    // Out-of-range reads carry no address, so they never pick up forwarded bytes.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < RD_LAT; k++)
            w_hit[k] = RDW_MODE != 0 && w_wr && r_pv[k] && !r_po[k] && r_pa[k] == w_idx;
    end

    always_ff @(posedge clk)
        for (int i = 0; i < NB; i++)
            if (w_we && w_wbe[i]) r_mem[w_widx][8*i +: 8] <= w_wd[8*i +: 8];

    always_ff @(posedge clk) begin
        if (w_rd) begin
            r_pd[0] <= w_oor ? INIT_VAL : r_mem[w_idx];
            r_pa[0] <= w_idx;
            r_po[0] <= w_oor;
        end
        for (int k = 1; k < RD_LAT; k++) begin
            r_pd[k] <= w_hit[k-1] ? merge(r_pd[k-1], wdata, ben) : r_pd[k-1];
            r_pa[k] <= r_pa[k-1];
            r_po[k] <= r_po[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            busy    <= 1'b1;
            r_pv    <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            oor_err <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == PW'(DEPTH - 1)) begin
                    r_state <= S_RUN;
                    busy    <= 1'b0;
                end
            end
            if (w_acc && w_oor) oor_err <= 1'b1;
            r_pv[0] <= w_rd;
            for (int k = 1; k < RD_LAT; k++) r_pv[k] <= r_pv[k-1];
            rvalid <= r_pv[RD_LAT-1];
            if (r_pv[RD_LAT-1])
                rdata <= w_hit[RD_LAT-1] ? merge(r_pd[RD_LAT-1], wdata, ben) : r_pd[RD_LAT-1];
        end
    end
endmodule

// File: tb/tb_sram_param.sv
// tb_sram_param: directed checks of a default sram_param and of a 32-bit,
// DEPTH=3000, RD_LAT=3, write-through configuration.
module tb_sram_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic        rst0_n, csb0, wrb0, rvalid0, busy0, oor0;
    logic [11:0] abus0;
    logic [0:0]  ben0;
    logic [7:0]  wdata0, rdata0;

    logic        rst1_n, csb1, wrb1, rvalid1, busy1, oor1;
    logic [11:0] abus1;
    logic [3:0]  ben1;
    logic [31:0] wdata1, rdata1;

    localparam logic [31:0] IV1 = 32'hC3C3_C3C3;

    sram_param u0 (
        .clk(clk), .rst_n(rst0_n), .csb(csb0), .wrb(wrb0), .abus(abus0), .ben(ben0),
        .wdata(wdata0), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0), .oor_err(oor0)
    );

    sram_param #(.DATA_W(32), .ADDR_W(12), .DEPTH(3000), .RD_LAT(3), .RDW_MODE(1), .INIT_VAL(IV1)) u1 (
        .clk(clk), .rst_n(rst1_n), .csb(csb1), .wrb(wrb1), .abus(abus1), .ben(ben1),
        .wdata(wdata1), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .oor_err(oor1)
    );

    int rv0_cnt = 0;
    int rv1_cnt = 0;
    always @(negedge clk) begin
        if (rvalid0) rv0_cnt++;
        if (rvalid1) rv1_cnt++;
    end

    typedef struct {
        bit          wr;
        logic [11:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
        bit          oor;
    } vec_t;
    vec_t tbl[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic sweep_len(input bit which, output int n);
        n = 0;
        while ((which ? busy1 : busy0) && n < 10000) begin
            n++;
            tick();
        end
    endtask

    task automatic op0(input bit w, input logic [11:0] a, input logic [7:0] d);
        csb0 = 1'b0; wrb0 = ~w; abus0 = a; ben0 = 1'b1; wdata0 = d;
        tick();
        csb0 = 1'b1; wrb0 = 1'b1;
    endtask

    task automatic op1(input bit w, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        csb1 = 1'b0; wrb1 = ~w; abus1 = a; ben1 = be; wdata1 = d;
        tick();
        csb1 = 1'b1; wrb1 = 1'b1;
    endtask

    task automatic rd1_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        op1(1'b0, a, 4'h0, 32'h0);
        tick();
        tick();
        chk({nm, "_early"}, rvalid1, 1'b0);
        tick();
        chk({nm, "_rv"}, rvalid1, 1'b1);
        chk({nm, "_rd"}, rdata1, exp);
    endtask

    initial begin
        int n;
        int r;
        tbl[0]  = '{1'b1, 12'h010, 4'hF, 32'h11223344, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 12'h010, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 12'h010, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        tbl[3]  = '{1'b1, 12'h123, 4'h1, 32'h000000A5, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 12'h123, 4'h0, 32'h0,        32'hC3C3C3A5, 1'b0};
        tbl[5]  = '{1'b1, 12'h020, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 12'h020, 4'h0, 32'h0,        IV1,          1'b0};
        tbl[7]  = '{1'b1, 12'hBB7, 4'hF, 32'h12345678, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 12'hBB7, 4'h0, 32'h0,        32'h12345678, 1'b0};
        tbl[9]  = '{1'b0, 12'h005, 4'h0, 32'h0,        IV1,          1'b0};
        tbl[10] = '{1'b1, 12'hBB8, 4'hF, 32'h99999999, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 12'hBB8, 4'h0, 32'h0,        IV1,          1'b1};
        tbl[12] = '{1'b0, 12'hFFF, 4'h0, 32'h0,        IV1,          1'b1};
        tbl[13] = '{1'b0, 12'hBB7, 4'h0, 32'h0,        32'h12345678, 1'b1};

        rst0_n = 1'b0; csb0 = 1'b1; wrb0 = 1'b1; abus0 = '0; ben0 = '0; wdata0 = '0;
        rst1_n = 1'b0; csb1 = 1'b1; wrb1 = 1'b1; abus1 = '0; ben1 = '0; wdata1 = '0;
        tick();
        tick();
        chk("rst_busy0", busy0, 1'b1);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rdata0", rdata0, 8'h00);
        chk("rst_oor0", oor0, 1'b0);
        chk("rst_busy1", busy1, 1'b1);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_oor1", oor1, 1'b0);

        rst0_n = 1'b1;
        sweep_len(1'b0, n);
        chk("u0_sweep_len", n, 4096);
        op0(1'b0, 12'hFFF, 8'h00);
        chk("u0_rd_early", rvalid0, 1'b0);
        tick();
        chk("u0_rd_rv", rvalid0, 1'b1);
        chk("u0_rd_fff", rdata0, 8'h00);

        op0(1'b0, 12'h007, 8'h00);
        op0(1'b1, 12'h007, 8'h5A);
        chk("u0_rdw_rv", rvalid0, 1'b1);
        chk("u0_rdw_old", rdata0, 8'h00);
        op0(1'b0, 12'h007, 8'h00);
        tick();
        chk("u0_rd_new", rdata0, 8'h5A);
        chk("u0_no_oor", oor0, 1'b0);

        op0(1'b0, 12'h007, 8'h00);
        r = rv0_cnt;
        rst0_n = 1'b0;
        tick();
        chk("u0_rst_rvalid", rvalid0, 1'b0);
        chk("u0_rst_rdata", rdata0, 8'h00);
        chk("u0_rst_busy", busy0, 1'b1);
        rst0_n = 1'b1;
        repeat (100) tick();
        chk("u0_midsweep_busy", busy0, 1'b1);
        rst0_n = 1'b0;
        tick();
        chk("u0_rst2_busy", busy0, 1'b1);
        rst0_n = 1'b1;
        sweep_len(1'b0, n);
        chk("u0_resweep_len", n, 4096);
        chk("u0_no_stray_rv", rv0_cnt, r);
        op0(1'b0, 12'h007, 8'h00);
        tick();
        chk("u0_reinit_rv", rvalid0, 1'b1);
        chk("u0_reinit_rd", rdata0, 8'h00);

        rst1_n = 1'b1;
        op1(1'b1, 12'h005, 4'hF, 32'h0);
        op1(1'b0, 12'hFFF, 4'h0, 32'h0);
        chk("u1_busy_oor", oor1, 1'b0);
        sweep_len(1'b1, n);
        chk("u1_sweep_len", n + 2, 3000);
        chk("u1_busy_norv", rv1_cnt, 0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) op1(1'b1, tbl[i].a, tbl[i].be, tbl[i].d);
            else rd1_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
            chk($sformatf("tbl%0d_oor", i), oor1, tbl[i].oor);
        end
        tick();
        chk("u1_hold_rv", rvalid1, 1'b0);
        chk("u1_hold_rd", rdata1, 32'h12345678);

        op1(1'b0, 12'h007, 4'h0, 32'h0);
        op1(1'b1, 12'h007, 4'hF, 32'h0000005A);
        tick();
        tick();
        chk("u1_fwd1_rv", rvalid1, 1'b1);
        chk("u1_fwd1_rd", rdata1, 32'h0000005A);

        op1(1'b0, 12'h008, 4'h0, 32'h0);
        tick();
        op1(1'b1, 12'h008, 4'b0010, 32'h0000AB00);
        tick();
        chk("u1_fwd2_rv", rvalid1, 1'b1);
        chk("u1_fwd2_rd", rdata1, 32'hC3C3ABC3);

        op1(1'b0, 12'h009, 4'h0, 32'h0);
        op1(1'b1, 12'h00A, 4'hF, 32'hFFFFFFFF);
        tick();
        tick();
        chk("u1_nofwd_rd", rdata1, IV1);
        rd1_chk("u1_arr8", 12'h008, 32'hC3C3ABC3);

        op1(1'b0, 12'h010, 4'h0, 32'h0);
        op1(1'b0, 12'h123, 4'h0, 32'h0);
        op1(1'b0, 12'h000, 4'h0, 32'h0);
        tick();
        chk("u1_b2b0_rv", rvalid1, 1'b1);
        chk("u1_b2b0_rd", rdata1, 32'h11BB33DD);
        tick();
        chk("u1_b2b1_rv", rvalid1, 1'b1);
        chk("u1_b2b1_rd", rdata1, 32'hC3C3C3A5);
        tick();
        chk("u1_b2b2_rv", rvalid1, 1'b1);
        chk("u1_b2b2_rd", rdata1, IV1);
        tick();
        chk("u1_b2b_end", rvalid1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_param.md
SRAM_PARAM -- requirements
Module: sram_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL provide parameter ADDR_W, default 12, address bus width in bits.
REQ-003 SHALL provide parameter DEPTH, default 4096, number of words; legal range is 1 to 2**ADDR_W.
REQ-004 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal range is 1 to 3.
REQ-005 SHALL provide parameter RDW_MODE, default 0, read-during-write behaviour: 0 returns old data, 1 returns new data (write-through).
REQ-006 SHALL provide parameter INIT_VAL, default 0, DATA_W-bit value written to every word during the init sweep.
REQ-007 SHALL use one clock and an asynchronous, active-low reset.
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 csb  input  1  active-low chip select; an access is taken when csb=0 in a cycle.
REQ-011 wrb  input  1  active-low write control, sampled with csb: 0 = write, 1 = read.
REQ-012 abus  input  ADDR_W  word address.
REQ-013 ben  input  DATA_W/8  byte enables for writes, active-high, bit i covers byte i.
REQ-014 wdata  input  DATA_W  write data.
REQ-015 rdata  output  DATA_W  read data, valid only while rvalid=1.
REQ-016 rvalid  output  1  one-cycle pulse for each completed read.
REQ-017 busy  output  1  high while the init sweep runs.
REQ-018 oor_err  output  1  sticky flag, set on any access with abus >= DEPTH.

Function
REQ-019 SHALL implement FSM states INIT and RUN; reset SHALL force the FSM to INIT with the sweep pointer at 0.
REQ-020 In INIT, SHALL write INIT_VAL to address ptr each cycle, then increment ptr.
REQ-021 In INIT, when ptr = DEPTH-1 is written, SHALL move to RUN on the next cycle; a full sweep SHALL take exactly DEPTH cycles.
REQ-022 SHALL drive busy=1 exactly while in INIT; any csb=0 access while busy=1 SHALL be ignored, with no write, no rvalid and no oor_err update.
REQ-023 In RUN, a write SHALL update, at that clock edge, only the bytes whose ben bit is 1; a write with ben=0 SHALL change nothing.
REQ-024 In RUN, a read issued at edge N SHALL produce rvalid=1 and rdata at edge N+RD_LAT, with a pipeline sustaining one read per cycle.
REQ-025 When RDW_MODE=1, a read to an address with a write issued in the same cycle SHALL return the merged new data.
REQ-026 When RDW_MODE=1 and a write hits an address whose read is still in the pipeline, the pipeline SHALL update the enabled bytes of the in-flight data.
REQ-027 When RDW_MODE=0, every read SHALL return the array contents from before any write in its issue cycle.
REQ-028 Any access with abus >= DEPTH SHALL set oor_err, suppress the write, and for a read still pulse rvalid with rdata = INIT_VAL.
REQ-029 oor_err SHALL be cleared only by reset.
REQ-030 While rvalid=0, rdata SHALL hold its last value.
REQ-031 The sweep pointer SHALL be sized ceil(log2(DEPTH+1)) bits and SHALL never wrap.

Reset
REQ-032 While rst_n=0, outputs SHALL be busy=1, rvalid=0, rdata=0, oor_err=0, and all read-pipeline valid bits SHALL be cleared.
REQ-033 Reset asserted mid-sweep or mid-read SHALL abort the operation, and no rvalid from a pre-reset read SHALL appear after reset.
REQ-034 After reset deassertion, SHALL restart the sweep from address 0.

Verification
REQ-035 Default parameters, release reset -> busy=1 for exactly 4096 cycles; then a read at 0xFFF returns 0x00 one cycle later.
REQ-036 Write 0xA5 at 0x123, then read 0x123 with RD_LAT=3 -> rvalid is 1 exactly 3 cycles after issue, rdata=0xA5.
REQ-037 DATA_W=32, word at 0x10 = 0x11223344, write 0xAABBCCDD with ben=4'b0101 -> read returns 0x11BB33DD.
REQ-038 Same-cycle write 0x5A and read at 0x7: RDW_MODE=0 -> returns the old value 0x00; RDW_MODE=1 -> returns 0x5A.
REQ-039 DEPTH=3000: write at 0xBB8 -> oor_err=1 and the array is unchanged; a read at 0xBB8 returns INIT_VAL with rvalid.
REQ-040 Assert rst_n=0 at sweep cycle 100 and during an in-flight read -> no stray rvalid appears; the sweep restarts at 0 and takes the full DEPTH cycles.
